sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock, parametrised FIFO for same-domain buffering between pipeline stages.
//  Extends the dual-clock FIFO: occupancy count, runtime almost-full/almost-empty thresholds,
//  selectable standard/first-word-fall-through read mode, flush, sticky overflow/underflow flags.
//  Self-contained: storage array is internal.
// PARAMETERS
//  DWIDTH  8  data width in bits
//  AWIDTH  4  address width; DEPTH = 2**AWIDTH entries
//  FWFT    0  0 = standard read (registered rdata, 1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk         in   1         clock; all logic on rising edge
//  rst         in   1         synchronous reset, active-high
//  flush       in   1         synchronous clear of pointers/count; storage contents untouched
//  wren        in   1         write request
//  wdata       in   DWIDTH    write data
//  rden        in   1         read request (FWFT=1: pop the head entry)
//  rdata       out  DWIDTH    read data
//  rvalid      out  1         rdata valid (FWFT=0: pulse 1 cycle after accepted read; FWFT=1: = ~rempty)
//  wfull       out  1         count == DEPTH
//  rempty      out  1         count == 0
//  af_thresh   in   AWIDTH+1  almost-full threshold; 0 disables almost_full
//  ae_thresh   in   AWIDTH+1  almost-empty threshold
//  almost_full out  1         (af_thresh != 0) && (count >= af_thresh)
//  almost_empty out 1         count <= ae_thresh
//  count       out  AWIDTH+1  current occupancy, 0..DEPTH
//  overflow    out  1         sticky: write attempted while wfull
//  underflow   out  1         sticky: read attempted while rempty
//  clr_err     in   1         clears overflow/underflow next edge
// BEHAVIOUR
//  - Reset (rst=1 at edge): wptr=rptr=0, count=0, rvalid=0, rdata reg=0, overflow=underflow=0.
//    So after reset: rempty=1, wfull=0, almost_empty=1, almost_full=0.
//  - wfull/rempty/almost_* are combinational decodes of registered count; no added latency.
//  - Write accepted: wacc = wren & ~wfull (flag state before the edge). Writes mem[wptr], wptr+1.
//  - Read accepted:  racc = rden & ~rempty. rptr+1.
//  - Pointers AWIDTH bits, wrap DEPTH-1 -> 0 naturally; count width AWIDTH+1, never wraps.
//  - count_next = count + wacc - racc; both accepted -> count unchanged.
//  - Full + wren + rden: read accepted, write rejected, overflow set. No write-through.
//  - Empty + wren + rden: write accepted, read rejected, underflow set. No bypass.
//  - FWFT=0: on racc, rdata <= mem[rptr] and rvalid <= 1 next cycle; else rvalid <= 0,
//    rdata holds last value.
//  - FWFT=1: rdata = mem[rptr] combinationally; valid whenever rempty=0; rden pops.
//    Data written at edge N is visible on rdata after edge N when FIFO was empty.
//  - flush: wptr=rptr=0, count=0, rvalid=0 at next edge; overrides wren/rden same cycle
//    (no write, no read, no error flag set). Sticky flags unchanged by flush.
//  - overflow/underflow: set by rejected request; priority rst > set > clr_err. A set and
//    clr_err in the same cycle leaves the flag set.
//  - Thresholds sampled combinationally each cycle; may change at any time.
//  - Reset mid-operation: all state discarded per reset values above; in-flight rvalid dropped.
// TESTING
//  1 Reset: hold rst 2 cycles -> rempty=1, wfull=0, count=0, almost_empty=1, rvalid=0, flags 0.
//  2 Fill/drain (AWIDTH=4): write 0x00..0x0F -> wfull=1, count=16; 17th write -> overflow=1,
//    count stays 16; read 16 -> data 0x00..0x0F in order, rempty=1; one more rden -> underflow=1.
//  3 Wrap: 10 writes, 10 reads, then 12 writes/12 reads -> order preserved across pointer wrap,
//    count returns to 0.
//  4 Simultaneous: at count=16 assert wren+rden -> count 15, overflow=1; at count=0 assert
//    wren+rden -> count 1, underflow=1; at count=5 -> count stays 5, data intact.
//  5 Thresholds: af_thresh=12, ae_thresh=3 -> almost_empty=1 at count 0..3, 0 at 4;
//    almost_full=0 at 11, 1 at 12; af_thresh=0 -> almost_full=0 even at count=16.
//  6 Modes/flush: FWFT=0 read -> rdata/rvalid one cycle after rden; FWFT=1 write 0xA5 to empty
//    -> rdata=0xA5, rvalid=1 next cycle; flush with wren+rden at count=7 -> count=0, no flags.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// Bus bundle for sync_fifo_ctrl: write/read handshake, thresholds, status and error flags.
// The master drives requests and thresholds; the slave (the FIFO) drives data and status.
interface sync_fifo_ctrl_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic              flush;
   logic              wren;
   logic [DWIDTH-1:0] wdata;
   logic              rden;
   logic [DWIDTH-1:0] rdata;
   logic              rvalid;
   logic              wfull;
   logic              rempty;
   logic [AWIDTH:0]   af_thresh;
   logic [AWIDTH:0]   ae_thresh;
   logic              almost_full;
   logic              almost_empty;
   logic [AWIDTH:0]   count;
   logic              overflow;
   logic              underflow;
   logic              clr_err;

   modport master (
      output flush, wren, wdata, rden, af_thresh, ae_thresh, clr_err,
      input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wren, wdata, rden, af_thresh, ae_thresh, clr_err,
      output rdata, rvalid, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, runtime almost-full/empty thresholds, flush,
// sticky overflow/underflow flags and a standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4,
   parameter int FWFT   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   sync_fifo_ctrl_if.slave       bus
);
   localparam int              DEPTH   = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [AWIDTH-1:0] wptr_q, wptr_d;
   logic [AWIDTH-1:0] rptr_q, rptr_d;
   logic [AWIDTH:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wfull, rempty;
   logic              wacc, racc;

   assign wfull  = (count_q == DEPTH_C);
   assign rempty = (count_q == '0);

   // Flush wins over both requests, so it can never accept data nor raise an error flag.
   assign wacc = bus.wren & ~wfull  & ~bus.flush;
   assign racc = bus.rden & ~rempty & ~bus.flush;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         wptr_d  = wptr_q + AWIDTH'(wacc);
         rptr_d  = rptr_q + AWIDTH'(racc);
         count_d = count_q + (AWIDTH + 1)'(wacc) - (AWIDTH + 1)'(racc);
      end
      if (bus.clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wren & wfull & ~bus.flush) overflow_d = 1'b1;
      if (bus.rden & rempty & ~bus.flush) underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never reset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (wacc) mem_q[wptr_q] <= bus.wdata;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign bus.rdata  = mem_q[rptr_q];
         assign bus.rvalid = ~rempty;
      end else begin : g_std
         logic [DWIDTH-1:0] rdata_q, rdata_d;
         logic              rvalid_q, rvalid_d;

         always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = racc;
            if (racc) rdata_d = mem_q[rptr_q];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rdata_q  <= rdata_d;
               rvalid_q <= rvalid_d;
            end
         end

         assign bus.rdata  = rdata_q;
         assign bus.rvalid = rvalid_q;
      end
   endgenerate

   assign bus.wfull        = wfull;
   assign bus.rempty       = rempty;
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
   assign bus.almost_full  = (bus.af_thresh != '0) && (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives a standard-read and a FWFT instance with identical stimulus and compares both
// against a queue-based reference model after every clock edge.
module tb_sync_fifo_ctrl;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst, flush, wren, rden, clr_err;
   logic [DW-1:0] wdata;
   logic [AW:0]   af_thresh, ae_thresh;

   always #5 clk = ~clk;

   sync_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) if0 ();
   sync_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) if1 ();

   assign if0.flush = flush;  assign if1.flush = flush;
   assign if0.wren  = wren;   assign if1.wren  = wren;
   assign if0.wdata = wdata;  assign if1.wdata = wdata;
   assign if0.rden  = rden;   assign if1.rden  = rden;
   assign if0.clr_err = clr_err;  assign if1.clr_err = clr_err;
   assign if0.af_thresh = af_thresh;  assign if1.af_thresh = af_thresh;
   assign if0.ae_thresh = ae_thresh;  assign if1.ae_thresh = ae_thresh;

   sync_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   sync_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   // Reference model: contents as a queue, plus sticky flags and the registered read port.
   logic [DW-1:0] mq[$];
   bit            m_ovf, m_unf, m_rv0;
   logic [DW-1:0] m_rd0;
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int n;
      n = mq.size();
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_unf = 0; m_rv0 = 0; m_rd0 = '0;
      end else begin
         if (clr_err) begin m_ovf = 0; m_unf = 0; end
         if (flush) begin
            mq.delete();
            m_rv0 = 0;
         end else begin
            if (wren && n == DEPTH) m_ovf = 1;
            if (rden && n == 0)     m_unf = 1;
            m_rv0 = 0;
            if (rden && n > 0) begin
               m_rd0 = mq.pop_front();
               m_rv0 = 1;
            end
            if (wren && n < DEPTH) mq.push_back(wdata);
         end
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      chk("count0", 32'(if0.count), 32'(n));
      chk("count1", 32'(if1.count), 32'(n));
      chk("wfull", 32'(if0.wfull), 32'(n == DEPTH));
      chk("rempty", 32'(if0.rempty), 32'(n == 0));
      chk("almost_full", 32'(if0.almost_full), 32'(af_thresh != 0 && n >= int'(af_thresh)));
      chk("almost_empty", 32'(if0.almost_empty), 32'(n <= int'(ae_thresh)));
      chk("overflow", 32'(if0.overflow), 32'(m_ovf));
      chk("underflow", 32'(if0.underflow), 32'(m_unf));
      chk("overflow1", 32'(if1.overflow), 32'(m_ovf));
      chk("underflow1", 32'(if1.underflow), 32'(m_unf));
      chk("rvalid0", 32'(if0.rvalid), 32'(m_rv0));
      chk("rdata0", 32'(if0.rdata), 32'(m_rd0));
      chk("rvalid1", 32'(if1.rvalid), 32'(n != 0));
      if (n != 0) chk("rdata1", 32'(if1.rdata), 32'(mq[0]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      $display("cyc %0d rst=%b fl=%b w=%b r=%b wd=%02h clr=%b -> count=%0d rv0=%b rd0=%02h ovf=%b unf=%b",
               cyc, rst, flush, wren, rden, wdata, clr_err, if0.count, if0.rvalid, if0.rdata,
               if0.overflow, if0.underflow);
      check_all();
   endtask

   task automatic op(input bit w, input bit r, input logic [DW-1:0] d);
      wren = w; rden = r; wdata = d;
      tick();
      wren = 0; rden = 0;
   endtask

   task automatic clear_flags();
      clr_err = 1; tick(); clr_err = 0;
   endtask

   initial begin
      rst = 1; flush = 0; wren = 0; rden = 0; clr_err = 0; wdata = '0;
      af_thresh = 5'd12; ae_thresh = 5'd3;
      tick(); tick();
      chk("rst_rempty", 32'(if0.rempty), 32'd1);
      chk("rst_wfull", 32'(if0.wfull), 32'd0);
      chk("rst_ae", 32'(if0.almost_empty), 32'd1);
      chk("rst_rvalid", 32'(if0.rvalid), 32'd0);
      rst = 0;

      // Fill, overflow, drain in order, underflow.
      for (int i = 0; i < DEPTH; i++) op(1, 0, DW'(i));
      chk("fill_full", 32'(if0.wfull), 32'd1);
      op(1, 0, 8'hEE);
      chk("ovf_set", 32'(if0.overflow), 32'd1);
      chk("ovf_count", 32'(if0.count), 32'd16);
      clear_flags();
      for (int i = 0; i < DEPTH; i++) begin
         chk("fwft_head", 32'(if1.rdata), 32'(i));
         op(0, 1, '0);
         chk("drain_data", 32'(if0.rdata), 32'(i));
      end
      chk("drain_empty", 32'(if0.rempty), 32'd1);
      op(0, 1, '0);
      chk("unf_set", 32'(if0.underflow), 32'd1);
      clear_flags();

      // Pointer wrap with random data.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < (k == 0 ? 10 : 12); i++) op(1, 0, DW'($urandom));
         for (int i = 0; i < (k == 0 ? 10 : 12); i++) op(0, 1, '0);
      end
      chk("wrap_count", 32'(if0.count), 32'd0);

      // Simultaneous requests at full, empty and mid occupancy.
      for (int i = 0; i < DEPTH; i++) op(1, 0, DW'($urandom));
      op(1, 1, 8'h5A);
      chk("sim_full_cnt", 32'(if0.count), 32'd15);
      chk("sim_full_ovf", 32'(if0.overflow), 32'd1);
      for (int i = 0; i < 15; i++) op(0, 1, '0);
      op(1, 1, 8'h3C);
      chk("sim_empty_cnt", 32'(if0.count), 32'd1);
      chk("sim_empty_unf", 32'(if0.underflow), 32'd1);
      clear_flags();
      for (int i = 0; i < 4; i++) op(1, 0, DW'($urandom));
      op(1, 1, 8'h77);
      chk("sim_mid_cnt", 32'(if0.count), 32'd5);
      for (int i = 0; i < 5; i++) op(0, 1, '0);

      // Threshold boundaries.
      for (int i = 0; i <= DEPTH; i++) begin
         chk("thr_ae", 32'(if0.almost_empty), 32'(i <= 3));
         chk("thr_af", 32'(if0.almost_full), 32'(i >= 12));
         if (i < DEPTH) op(1, 0, DW'($urandom));
      end
      af_thresh = '0;
      #1;
      chk("thr_af_off", 32'(if0.almost_full), 32'd0);
      af_thresh = 5'd12;
      for (int i = 0; i < DEPTH; i++) op(0, 1, '0);

      // Flush with both requests, then FWFT/standard read latency.
      for (int i = 0; i < 7; i++) op(1, 0, DW'($urandom));
      wren = 1; rden = 1; flush = 1; tick();
      wren = 0; rden = 0; flush = 0;
      chk("flush_cnt", 32'(if0.count), 32'd0);
      chk("flush_ovf", 32'(if0.overflow), 32'd0);
      chk("flush_unf", 32'(if0.underflow), 32'd0);
      op(1, 0, 8'hA5);
      chk("fwft_data", 32'(if1.rdata), 32'hA5);
      chk("fwft_valid", 32'(if1.rvalid), 32'd1);
      chk("std_novalid", 32'(if0.rvalid), 32'd0);
      op(0, 1, '0);
      chk("std_valid", 32'(if0.rvalid), 32'd1);
      chk("std_data", 32'(if0.rdata), 32'hA5);
      op(0, 0, '0);
      chk("std_pulse", 32'(if0.rvalid), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         wren    = ($urandom_range(0, 99) < 55);
         rden    = ($urandom_range(0, 99) < 50);
         wdata   = DW'($urandom);
         flush   = ($urandom_range(0, 49) == 0);
         clr_err = ($urandom_range(0, 29) == 0);
         rst     = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) begin
            af_thresh = (AW + 1)'($urandom_range(0, DEPTH));
            ae_thresh = (AW + 1)'($urandom_range(0, DEPTH));
         end
         tick();
      end
      rst = 0; flush = 0; clr_err = 0; wren = 0; rden = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
